// File: rtl/exc_redirect_pkg.sv
// Shared definitions for the exception/ERET redirect block: FSM states,
// CP0 exception codes, default exception vector and flush bit positions.
package exc_redirect_pkg;

  localparam int unsigned EXC_W   = 2;
  localparam int unsigned PC_W    = 32;
  localparam int unsigned FLUSH_W = 4;
  localparam int unsigned CNT_W   = 3;   // holds FLUSH_CYCLES up to 4

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_e;

  localparam logic [EXC_W-1:0] EXC_NONE  = 2'd0;
  localparam logic [EXC_W-1:0] EXC_NORM  = 2'd1;
  localparam logic [EXC_W-1:0] EXC_DSLOT = 2'd2;

  localparam logic [PC_W-1:0] EXC_VEC_DEFAULT = 32'hBFC00380;

  localparam int unsigned FLUSH_IF  = 0;
  localparam int unsigned FLUSH_ID  = 1;
  localparam int unsigned FLUSH_EX  = 2;
  localparam int unsigned FLUSH_MEM = 3;

  localparam logic [FLUSH_W-1:0] FLUSH_ALL =
    FLUSH_W'((1 << FLUSH_IF) | (1 << FLUSH_ID) | (1 << FLUSH_EX) | (1 << FLUSH_MEM));

  // Any non-zero code traps; delay-slot and normal exceptions are handled alike.
  function automatic logic is_exception(logic [EXC_W-1:0] code);
    case (code)
      EXC_NONE:            is_exception = 1'b0;
      EXC_NORM, EXC_DSLOT: is_exception = 1'b1;
      default:             is_exception = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/exc_redirect_if.sv
// Bus between CP0/pipeline control and the redirect block.
//   master: drives exc, back, epc, pause, if_ready; observes redirect/flush/busy
//   slave : the redirect block itself
interface exc_redirect_if;
  import exc_redirect_pkg::*;

  logic [EXC_W-1:0]   exc;
  logic               back;
  logic [PC_W-1:0]    epc;
  logic               pause;
  logic               if_ready;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic [FLUSH_W-1:0] flush;
  logic               busy;

  modport master (
    output exc, back, epc, pause, if_ready,
    input  redirect_valid, redirect_pc, flush, busy
  );

  modport slave (
    input  exc, back, epc, pause, if_ready,
    output redirect_valid, redirect_pc, flush, busy
  );
endinterface

// File: rtl/exc_redirect.sv
// Exception / ERET redirect controller. On an accepted event it kills all
// pipeline stages for FLUSH_CYCLES cycles, then requests a fetch redirect to
// the exception vector (exception) or EPC (ERET) until fetch accepts it.
// Ports:
//   clk      - clock
//   rst      - synchronous active-low reset
//   bus      - exc_redirect_if.slave (exc/back/epc/pause/if_ready in,
//              redirect_valid/redirect_pc/flush/busy out, all registered)
//   exc_cnt  - exception entry counter, present only with EXC_REDIRECT_CNT_EN
// Optional feature macro: EXC_REDIRECT_CNT_EN
module exc_redirect
  import exc_redirect_pkg::*;
#(
  parameter logic [PC_W-1:0] EXC_VEC      = EXC_VEC_DEFAULT,
  parameter int unsigned     FLUSH_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  exc_redirect_if.slave    bus
`ifdef EXC_REDIRECT_CNT_EN
  ,
  output logic [PC_W-1:0]  exc_cnt
`endif
);

  state_e             state_q, state_d;
  logic [PC_W-1:0]    target_q, target_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FLUSH_W-1:0] flush_q, flush_d;
  logic               rv_q, rv_d;
  logic [PC_W-1:0]    rpc_q, rpc_d;
  logic               busy_q, busy_d;
  logic               exc_take;
`ifdef EXC_REDIRECT_CNT_EN
  logic [PC_W-1:0]    exc_cnt_q, exc_cnt_d;
`endif

  // Next state, target/counter update and next registered outputs
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    exc_take = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Events are only sampled while the pipeline is not paused
        if (!bus.pause) begin
          if (is_exception(bus.exc)) begin
            exc_take = 1'b1;
            target_d = EXC_VEC;
            cnt_d    = CNT_W'(FLUSH_CYCLES);
            state_d  = ST_FLUSH;
          end else if (bus.back) begin
            target_d = bus.epc;
            cnt_d    = CNT_W'(FLUSH_CYCLES);
            state_d  = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_REDIRECT;
        end
      end
      ST_REDIRECT: begin
        if (bus.if_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    flush_d = (state_d == ST_FLUSH) ? FLUSH_ALL : '0;
    rv_d    = (state_d == ST_REDIRECT);
    rpc_d   = rv_d ? target_d : '0;
    busy_d  = (state_d != ST_IDLE);
  end

`ifdef EXC_REDIRECT_CNT_EN
  // Counts exception-caused flush entries only; wraps naturally
  always_comb begin
    exc_cnt_d = exc_cnt_q;
    if (exc_take) begin
      exc_cnt_d = exc_cnt_q + PC_W'(1);
    end
  end
`endif

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      target_q <= '0;
      cnt_q    <= '0;
      flush_q  <= '0;
      rv_q     <= 1'b0;
      rpc_q    <= '0;
      busy_q   <= 1'b0;
`ifdef EXC_REDIRECT_CNT_EN
      exc_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      flush_q  <= flush_d;
      rv_q     <= rv_d;
      rpc_q    <= rpc_d;
      busy_q   <= busy_d;
`ifdef EXC_REDIRECT_CNT_EN
      exc_cnt_q <= exc_cnt_d;
`endif
    end
  end

  assign bus.flush          = flush_q;
  assign bus.redirect_valid = rv_q;
  assign bus.redirect_pc    = rpc_q;
  assign bus.busy           = busy_q;
`ifdef EXC_REDIRECT_CNT_EN
  assign exc_cnt = exc_cnt_q;
`endif

endmodule

// File: tb/tb_exc_redirect.sv
// Bench for exc_redirect: two instances (FLUSH_CYCLES 1 and 3) share one
// stimulus stream and are checked every cycle against an event-schedule model.
module tb_exc_redirect;
  import exc_redirect_pkg::*;

  localparam logic [31:0] VEC = 32'hBFC00380;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  exc;
  logic        back;
  logic [31:0] epc;
  logic        pause;
  logic        if_ready;

  exc_redirect_if if0 ();
  exc_redirect_if if1 ();

  assign if0.exc = exc;   assign if1.exc = exc;
  assign if0.back = back; assign if1.back = back;
  assign if0.epc = epc;   assign if1.epc = epc;
  assign if0.pause = pause;       assign if1.pause = pause;
  assign if0.if_ready = if_ready; assign if1.if_ready = if_ready;

`ifdef EXC_REDIRECT_CNT_EN
  logic [31:0] cnt0, cnt1;
`endif

  exc_redirect #(.EXC_VEC(VEC), .FLUSH_CYCLES(1)) dut0 (
    .clk(clk), .rst(rst), .bus(if0)
`ifdef EXC_REDIRECT_CNT_EN
    , .exc_cnt(cnt0)
`endif
  );

  exc_redirect #(.EXC_VEC(VEC), .FLUSH_CYCLES(3)) dut1 (
    .clk(clk), .rst(rst), .bus(if1)
`ifdef EXC_REDIRECT_CNT_EN
    , .exc_cnt(cnt1)
`endif
  );

  // Model: remaining flush cycles, pending redirect, latched target, entry count
  int          flush_left [2] = '{0, 0};
  bit          redir      [2] = '{1'b0, 1'b0};
  logic [31:0] tgt        [2] = '{32'h0, 32'h0};
  logic [31:0] mcnt       [2] = '{32'h0, 32'h0};
  int          ncyc       [2] = '{1, 3};

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply the rules to the inputs present at this clock edge
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        flush_left[i] = 0;
        redir[i]      = 1'b0;
        tgt[i]        = 32'h0;
        mcnt[i]       = 32'h0;
      end else if (flush_left[i] > 0) begin
        flush_left[i]--;
        if (flush_left[i] == 0) redir[i] = 1'b1;
      end else if (redir[i]) begin
        if (if_ready) redir[i] = 1'b0;
      end else if (!pause) begin
        if (exc != 2'd0) begin
          tgt[i]        = VEC;
          flush_left[i] = ncyc[i];
          mcnt[i]       = mcnt[i] + 32'd1;
        end else if (back) begin
          tgt[i]        = epc;
          flush_left[i] = ncyc[i];
        end
      end
    end
  endtask

  function automatic logic [31:0] e_flush(input int i);
    return (flush_left[i] > 0) ? 32'hF : 32'h0;
  endfunction
  function automatic logic [31:0] e_pc(input int i);
    return redir[i] ? tgt[i] : 32'h0;
  endfunction
  function automatic logic [31:0] e_busy(input int i);
    return ((flush_left[i] > 0) || redir[i]) ? 32'h1 : 32'h0;
  endfunction

  task automatic check_all();
    chk("flush0", 32'(if0.flush), e_flush(0));
    chk("rv0",    32'(if0.redirect_valid), 32'(redir[0]));
    chk("pc0",    if0.redirect_pc, e_pc(0));
    chk("busy0",  32'(if0.busy), e_busy(0));
    chk("flush1", 32'(if1.flush), e_flush(1));
    chk("rv1",    32'(if1.redirect_valid), 32'(redir[1]));
    chk("pc1",    if1.redirect_pc, e_pc(1));
    chk("busy1",  32'(if1.busy), e_busy(1));
`ifdef EXC_REDIRECT_CNT_EN
    chk("cnt0", cnt0, mcnt[0]);
    chk("cnt1", cnt1, mcnt[1]);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b0; exc = 2'd0; back = 1'b0; epc = 32'h0; pause = 1'b0; if_ready = 1'b1;

    // Reset state
    step(); step();
    chk("rst_flush", 32'(if0.flush), 32'h0);
    chk("rst_busy",  32'(if0.busy), 32'h0);
    rst = 1'b1;
    step();

    // Exception, FLUSH_CYCLES=1: flush, redirect, idle on consecutive cycles
    exc = EXC_NORM;
    step();
    exc = EXC_NONE;
    chk("exc_flush_c1", 32'(if0.flush), 32'hF);
    step();
    chk("exc_rv_c2", 32'(if0.redirect_valid), 32'h1);
    chk("exc_pc_c2", if0.redirect_pc, VEC);
    step();
    chk("exc_busy_c3", 32'(if0.busy), 32'h0);
    repeat (4) step();

    // ERET with fetch stalled: redirect held 4 cycles, epc changes ignored
    back = 1'b1; epc = 32'h80001234; if_ready = 1'b0;
    step();
    back = 1'b0; epc = 32'hDEAD0000;
    step();
    for (int k = 0; k < 3; k++) begin
      chk("eret_rv_hold", 32'(if0.redirect_valid), 32'h1);
      chk("eret_pc_hold", if0.redirect_pc, 32'h80001234);
      epc = $urandom;
      step();
    end
    if_ready = 1'b1;
    chk("eret_rv_last", 32'(if0.redirect_valid), 32'h1);
    chk("eret_pc_last", if0.redirect_pc, 32'h80001234);
    step();
    chk("eret_rv_drop", 32'(if0.redirect_valid), 32'h0);
    repeat (6) step();

    // Delay-slot exception together with ERET: exception wins
    exc = EXC_DSLOT; back = 1'b1; epc = 32'h12345678;
    step();
    exc = EXC_NONE; back = 1'b0;
    step();
    chk("both_pc", if0.redirect_pc, VEC);
`ifdef EXC_REDIRECT_CNT_EN
    chk("both_cnt", cnt0, 32'h1);
`endif
    repeat (6) step();

    // Exception held under pause is taken once pause drops
    pause = 1'b1; exc = EXC_NORM;
    step();
    chk("pause_noflush_a", 32'(if0.flush), 32'h0);
    step();
    chk("pause_noflush_b", 32'(if0.flush), 32'h0);
    pause = 1'b0;
    step();
    exc = EXC_NONE;
    chk("pause_flush", 32'(if0.flush), 32'hF);
    repeat (6) step();

    // Reset in the second FLUSH cycle of the FLUSH_CYCLES=3 instance
    exc = EXC_NORM;
    step();
    exc = EXC_NONE;
    step();
    chk("mid_flush_busy", 32'(if1.busy), 32'h1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("rst_abort_flush", 32'(if1.flush), 32'h0);
    chk("rst_abort_busy",  32'(if1.busy), 32'h0);
    repeat (6) begin
      step();
      chk("rst_abort_norv", 32'(if1.redirect_valid), 32'h0);
    end

`ifdef EXC_REDIRECT_CNT_EN
    // Counter wrap from all-ones
    force dut0.exc_cnt_q = 32'hFFFFFFFF;
    mcnt[0] = 32'hFFFFFFFF;
    step();
    release dut0.exc_cnt_q;
    exc = EXC_NORM;
    step();
    exc = EXC_NONE;
    chk("cnt_wrap", cnt0, 32'h0);
    repeat (6) step();
`endif

    // Randomized traffic
    repeat (400) begin
      rst      = ($urandom_range(0, 59) != 0);
      exc      = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 2)) : EXC_NONE;
      back     = ($urandom_range(0, 4) == 0);
      epc      = $urandom;
      pause    = ($urandom_range(0, 3) == 0);
      if_ready = ($urandom_range(0, 1) == 0);
      step();
    end

    rst = 1'b1; exc = EXC_NONE; back = 1'b0; pause = 1'b0; if_ready = 1'b1;
    repeat (8) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/exc_redirect.md
EXC_REDIRECT -- requirements
Module: exc_redirect

Interface
REQ-001 Parameter EXC_VEC, default 32'hBFC00380: exception entry PC.
REQ-002 Parameter FLUSH_CYCLES, default 1, legal 1..4: cycles flush is held.
REQ-003 clk  input  1  sole clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 exc  input  2  exception code from CP0: 0 none, 1 exception, 2 exception in delay slot.
REQ-006 back  input  1  ERET seen by CP0.
REQ-007 epc  input  32  CP0 EPC value.
REQ-008 pause  input  1  pipeline stall; new events are not accepted while high.
REQ-009 if_ready  input  1  fetch stage accepts redirect this cycle.
REQ-010 redirect_valid  output  1  redirect request to fetch.
REQ-011 redirect_pc  output  32  target PC, stable while redirect_valid.
REQ-012 flush  output  4  per-stage kill, bit0 IF, bit1 ID, bit2 EX, bit3 MEM.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 FSM states: IDLE, FLUSH, REDIRECT.
REQ-015 IDLE, rst high, pause low, exc!=0: latch target=EXC_VEC, load flush counter with FLUSH_CYCLES, go to FLUSH next cycle.
REQ-016 IDLE, pause low, exc==0, back high: latch target=epc from that cycle, then proceed as in REQ-015.
REQ-017 exc!=0 and back both high in the same cycle: exception wins and target is EXC_VEC.
REQ-018 IDLE with pause high: exc and back are ignored, state unchanged. CP0 holds exc under pause, so the event is taken the first cycle pause is low.
REQ-019 FLUSH drives flush=4'b1111 every cycle and decrements the counter. On the cycle the counter reads 1 it moves to REDIRECT.
REQ-020 exc==2 and exc==1 produce identical flush and target. The delay-slot distinction is CP0's EPC concern only.
REQ-021 REDIRECT drives redirect_valid=1 and redirect_pc=target. It stays until a cycle with if_ready=1, then goes to IDLE.
REQ-022 Handshake: the transfer completes on the clock edge where redirect_valid and if_ready are both 1. redirect_valid deasserts the next cycle.
REQ-023 if_ready high outside REDIRECT has no effect.
REQ-024 exc, back and epc arriving in FLUSH or REDIRECT are ignored. No queueing.
REQ-025 Outside FLUSH, flush=0. Outside REDIRECT, redirect_valid=0 and redirect_pc=0.
REQ-026 pause does not stall FLUSH or REDIRECT progress.
REQ-027 Minimum event-to-IDLE latency is FLUSH_CYCLES+2 cycles, with if_ready tied high.

Reset
REQ-028 rst low at a clock edge forces: state IDLE, target=0, counter=0, redirect_valid=0, redirect_pc=0, flush=0, busy=0.
REQ-029 Reset in any state, including mid-FLUSH or mid-REDIRECT, aborts the operation without emitting a redirect.

Configuration
REQ-030 Macro EXC_REDIRECT_CNT_EN defined: adds output exc_cnt, 32 bits, reset 0, +1 on each FLUSH entry caused by an exception (not ERET), wrapping 32'hFFFFFFFF to 0.
REQ-031 EXC_REDIRECT_CNT_EN undefined: no exc_cnt port and no counter logic. All other behaviour is identical.

Structure
REQ-032 A shared package holds the FSM state enum, the exc code constants (EXC_NONE=0, EXC_NORM=1, EXC_DSLOT=2), the default EXC_VEC and the flush bit indices.
REQ-033 No sub-module. The FSM, target register and counters live in exc_redirect.

Verification
REQ-034 exc=1 for one cycle, pause=0, if_ready=1, FLUSH_CYCLES=1 -> flush=4'hF on cycle+1, redirect_valid=1 with redirect_pc=32'hBFC00380 on cycle+2, busy=0 on cycle+3.
REQ-035 back=1 with epc=32'h80001234, if_ready low for 3 cycles -> redirect_valid held for 4 cycles with pc 32'h80001234; epc changes meanwhile do not alter it.
REQ-036 exc=2 and back=1 together -> redirect_pc=32'hBFC00380; with EXC_REDIRECT_CNT_EN, exc_cnt 0->1.
REQ-037 exc=1 with pause=1 for 2 cycles, then pause=0 -> no flush during the pause; flush asserts on the cycle after pause drops.
REQ-038 FLUSH_CYCLES=3, rst low in the second FLUSH cycle -> next cycle flush=0, busy=0, no redirect_valid ever seen.
REQ-039 Counter preloaded near wrap (forced exc_cnt=32'hFFFFFFFF) + one exception -> exc_cnt=0.
